// File: rtl/icache_refill.sv
// icache_refill: direct-mapped instruction cache with a single outstanding
// refill. A hit returns its word one cycle after accept. A miss issues one
// refill request and writes the returned word into the set.
// Optional build feature: define ICACHE_STATS_EN to add saturating
// hit_count / miss_count outputs (32 bits each, cleared only by reset).
module icache_refill #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int SETS     = 16,
   parameter int OFFSET_W = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              flush,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instruction,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int INDEX_W = $clog2(SETS);
   localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
   localparam logic [ADDR_W-1:0] BLOCK_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MISS_REQ  = 2'd1,
      MISS_WAIT = 2'd2
   } state_t;

   state_t              state_q;
   logic [SETS-1:0]     valid_q;
   logic [TAG_W-1:0]    tag_mem_q  [SETS];
   logic [DATA_W-1:0]   data_mem_q [SETS];
   logic                flushed_q;
   logic                instr_valid_q;
   logic [DATA_W-1:0]   instruction_q;
   logic                mem_req_valid_q;
   logic [ADDR_W-1:0]   mem_req_addr_q;

   logic [INDEX_W-1:0]  req_index_s;
   logic [TAG_W-1:0]    req_tag_s;
   logic [ADDR_W-1:0]   block_addr_s;
   logic                accept_s;
   logic                hit_s;
   logic                fill_s;
   logic [INDEX_W-1:0]  fill_index_s;
   logic [TAG_W-1:0]    fill_tag_s;

   // Lookup decode, accept/hit detection and refill write strobe.
   // The refill target set/tag is taken from the latched request address.
   always_comb begin
      req_index_s  = pc[OFFSET_W +: INDEX_W];
      req_tag_s    = pc[ADDR_W-1 -: TAG_W];
      block_addr_s = pc & BLOCK_MASK;
      req_ready    = (state_q == IDLE) & ~flush;
      accept_s     = req_valid & req_ready;
      hit_s        = valid_q[req_index_s] & (tag_mem_q[req_index_s] == req_tag_s);
      fill_s       = (state_q == MISS_WAIT) & mem_resp_valid;
      fill_index_s = mem_req_addr_q[OFFSET_W +: INDEX_W];
      fill_tag_s   = mem_req_addr_q[ADDR_W-1 -: TAG_W];
   end

   // Control FSM with registered fetch/refill outputs. flushed_q remembers a
   // flush seen mid-refill so the returned line is delivered but not kept valid.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         instr_valid_q   <= 1'b0;
         instruction_q   <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= '0;
         flushed_q       <= 1'b0;
      end else begin
         instr_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  if (hit_s) begin
                     instr_valid_q <= 1'b1;
                     instruction_q <= data_mem_q[req_index_s];
                  end else begin
                     state_q         <= MISS_REQ;
                     mem_req_valid_q <= 1'b1;
                     mem_req_addr_q  <= block_addr_s;
                     flushed_q       <= 1'b0;
                  end
               end
            end
            MISS_REQ: begin
               if (flush) begin
                  flushed_q <= 1'b1;
               end
               if (mem_req_ready) begin
                  state_q         <= MISS_WAIT;
                  mem_req_valid_q <= 1'b0;
               end
            end
            MISS_WAIT: begin
               if (flush) begin
                  flushed_q <= 1'b1;
               end
               if (mem_resp_valid) begin
                  instr_valid_q <= 1'b1;
                  instruction_q <= mem_resp_data;
                  state_q       <= IDLE;
               end
            end
            default: begin
               state_q         <= IDLE;
               mem_req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Valid bits: flush wipes everything; a refill marks its set valid unless
   // a flush arrived during that refill (including on the fill edge itself).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (fill_s) begin
         valid_q[fill_index_s] <= ~flushed_q;
      end
   end

   // Tag/data arrays are plain storage; the valid bits guard their contents.
   always_ff @(posedge clock) begin
      if (fill_s) begin
         tag_mem_q[fill_index_s]  <= fill_tag_s;
         data_mem_q[fill_index_s] <= mem_resp_data;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count_q;
   logic [31:0] miss_count_q;

   // Saturating hit/miss counters per accepted request; only reset clears them.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
      end else if (accept_s) begin
         if (hit_s) begin
            if (hit_count_q != 32'hFFFF_FFFF) begin
               hit_count_q <= hit_count_q + 32'd1;
            end
         end else begin
            if (miss_count_q != 32'hFFFF_FFFF) begin
               miss_count_q <= miss_count_q + 32'd1;
            end
         end
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

   assign instr_valid   = instr_valid_q;
   assign instruction   = instruction_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr  = mem_req_addr_q;

endmodule

// File: tb/tb_icache_refill.sv
// Testbench for icache_refill: directed vectors, a cache-level reference
// model updated on each rising edge, and a per-cycle compare on falling edges.
module tb_icache_refill;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 16;
   localparam int OW = 3;

   logic          clock;
   logic          reset_n;
   logic [AW-1:0] pc;
   logic          req_valid;
   logic          req_ready;
   logic          flush;
   logic          instr_valid;
   logic [DW-1:0] instruction;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [AW-1:0] mem_req_addr;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;
`endif

   icache_refill #(.ADDR_W(AW), .DATA_W(DW), .SETS(NS), .OFFSET_W(OW)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .pc             (pc),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .flush          (flush),
      .instr_valid    (instr_valid),
      .instruction    (instruction),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count      (hit_count),
      .miss_count     (miss_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (cache contents + pending refill) ----
   bit            m_valid [NS];
   logic [AW-1:0] m_blk   [NS];
   logic [DW-1:0] m_data  [NS];
   bit            m_pend;      // a refill is outstanding
   bit            m_sent;      // its request has been handshaken
   bit            m_fl;        // a flush was seen while it was outstanding
   logic [AW-1:0] m_addr;
   bit            e_iv;
   logic [DW-1:0] e_instr;
   int unsigned   m_hits;
   int unsigned   m_misses;

   function automatic int unsigned set_of(input logic [AW-1:0] a);
      return (a >> OW) % NS;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      m_pend = 1'b0; m_sent = 1'b0; m_fl = 1'b0; m_addr = '0;
      e_iv = 1'b0; e_instr = '0; m_hits = 0; m_misses = 0;
   endtask

   task automatic model_step();
      int unsigned s;
      e_iv = 1'b0;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (m_pend && !m_sent) begin
         if (mem_req_ready) m_sent = 1'b1;
      end else if (m_pend) begin
         if (mem_resp_valid) begin
            s = set_of(m_addr);
            m_blk[s]   = m_addr >> OW;
            m_data[s]  = mem_resp_data;
            m_valid[s] = !(m_fl || flush);
            e_iv = 1'b1; e_instr = mem_resp_data;
            m_pend = 1'b0;
         end
      end else if (req_valid && !flush) begin
         s = set_of(pc);
         if (m_valid[s] && m_blk[s] == (pc >> OW)) begin
            e_iv = 1'b1; e_instr = m_data[s]; m_hits++;
         end else begin
            m_pend = 1'b1; m_sent = 1'b0; m_fl = 1'b0;
            m_addr = (pc >> OW) << OW; m_misses++;
         end
      end
      if (flush) begin
         for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
         if (m_pend) m_fl = 1'b1;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clock);
         model_step();
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock) begin
      chk("cyc_instr_valid", instr_valid, e_iv);
      chk("cyc_instruction", instruction, e_instr);
      chk("cyc_mem_req_valid", mem_req_valid, m_pend && !m_sent);
      chk("cyc_req_ready", req_ready, !m_pend && !flush);
      if (m_pend && !m_sent) chk("cyc_mem_req_addr", mem_req_addr, m_addr);
`ifdef ICACHE_STATS_EN
      chk("cyc_hit_count", hit_count, m_hits);
      chk("cyc_miss_count", miss_count, m_misses);
`endif
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_miss(input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
      pc = a; req_valid = 1'b1; mem_req_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      chk("miss_req_valid", mem_req_valid, 1'b1);
      chk("miss_req_addr", mem_req_addr, (a >> OW) << OW);
      chk("miss_no_iv", instr_valid, 1'b0);
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("stall_req_valid", mem_req_valid, 1'b1);
         chk("stall_req_addr", mem_req_addr, (a >> OW) << OW);
         chk("stall_req_ready", req_ready, 1'b0);
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("after_hs_req_valid", mem_req_valid, 1'b0);
      mem_resp_valid = 1'b1; mem_resp_data = d;
      tick();
      mem_resp_valid = 1'b0;
      chk("fill_iv", instr_valid, 1'b1);
      chk("fill_data", instruction, d);
   endtask

   task automatic do_hit(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pc = a; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("hit_iv", instr_valid, 1'b1);
      chk("hit_data", instruction, d);
      chk("hit_no_mreq", mem_req_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; pc = '0; req_valid = 1'b0; flush = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      repeat (3) tick();
      chk("rst_iv", instr_valid, 1'b0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_mreq", mem_req_valid, 1'b0);
      chk("rst_addr", mem_req_addr, 32'h0);
      chk("rst_ready", req_ready, 1'b1);
      reset_n = 1'b1;
      tick();

      // Cold miss: three cycles accept to data.
      do_miss(32'h100, 32'h910006D6, 0);
`ifdef ICACHE_STATS_EN
      chk("miss_count_1", miss_count, 32'd1);
`endif
      tick();
      chk("pulse_ends", instr_valid, 1'b0);
      chk("instr_holds", instruction, 32'h910006D6);

      // Back-to-back hits.
      pc = 32'h100; req_valid = 1'b1;
      tick();
      chk("b2b_hit1", instr_valid, 1'b1);
      chk("b2b_data1", instruction, 32'h910006D6);
      tick();
      chk("b2b_hit2", instr_valid, 1'b1);
      chk("b2b_nomreq", mem_req_valid, 1'b0);
      req_valid = 1'b0;
      tick();
      chk("b2b_end", instr_valid, 1'b0);
`ifdef ICACHE_STATS_EN
      chk("hit_count_2", hit_count, 32'd2);
`endif

      // Eviction: 0x180 shares set 0 with 0x100.
      do_miss(32'h180, 32'hDEADBEEF, 0);
      do_miss(32'h100, 32'h910006D6, 0);
      do_hit(32'h100, 32'h910006D6);

      // Stalled request handshake, then hit on another offset of the block.
      do_miss(32'h208, 32'h12345678, 5);
      do_hit(32'h20C, 32'h12345678);

      // Stray response while idle is ignored.
      mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0BAD0;
      tick();
      mem_resp_valid = 1'b0;
      chk("stray_resp_iv", instr_valid, 1'b0);
      chk("stray_resp_data", instruction, 32'h12345678);

      // Flush in idle blocks acceptance and invalidates.
      pc = 32'h208; req_valid = 1'b1; flush = 1'b1;
      #1;
      chk("flush_ready", req_ready, 1'b0);
      tick();
      flush = 1'b0; req_valid = 1'b0;
      chk("flush_no_iv", instr_valid, 1'b0);
      chk("flush_no_mreq", mem_req_valid, 1'b0);
      do_miss(32'h208, 32'h12345678, 0);

      // Flush during MISS_WAIT: data delivered, line not kept.
      pc = 32'h308; req_valid = 1'b1; mem_req_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      mem_req_ready = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hFADECAFE;
      tick();
      mem_resp_valid = 1'b0;
      chk("flushwait_iv", instr_valid, 1'b1);
      chk("flushwait_data", instruction, 32'hFADECAFE);
      do_miss(32'h308, 32'h0BADF00D, 0);

      // Flush on the same edge as the response.
      pc = 32'h408; req_valid = 1'b1; mem_req_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      mem_req_ready = 1'b0; flush = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0A0B0C0D;
      tick();
      flush = 1'b0; mem_resp_valid = 1'b0;
      chk("flushfill_iv", instr_valid, 1'b1);
      chk("flushfill_data", instruction, 32'h0A0B0C0D);
      do_miss(32'h408, 32'h0A0B0C0D, 0);

      // Reset in MISS_REQ drops the request immediately.
      do_miss(32'h100, 32'h910006D6, 0);
      pc = 32'h180; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("pre_rst_mreq", mem_req_valid, 1'b1);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_mreq", mem_req_valid, 1'b0);
      chk("async_rst_addr", mem_req_addr, 32'h0);
      chk("async_rst_instr", instruction, 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      do_miss(32'h100, 32'h910006D6, 0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
